// File: rtl/fifo_rdctl.sv
// Read-side controller for a dual-clock FIFO: issues memory reads and keeps a
// two-word skid buffer so a registered-read RAM can stream one word per cycle.
module fifo_rdctl #(
  parameter int data_width = 16,
  parameter int addr_width = 8
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [addr_width:0]   wptr,
  output logic [addr_width-1:0] raddr,
  output logic                  rclken,
  input  logic [data_width-1:0] rdata,
  output logic                  rempty,
  output logic [addr_width:0]   rlevel,
  input  logic                  flush,
  output logic [data_width-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  logic [addr_width:0]   rptr_reg, rptr_next;
  logic [1:0]            occ_reg, occ_next;
  logic                  inflight_reg, inflight_next;
  logic [data_width-1:0] buf_reg  [2];
  logic [data_width-1:0] buf_next [2];

  logic       pop;
  logic       issue;
  logic [2:0] demand;
  logic [2:0] limit;
  logic [1:0] tail;

  assign rempty  = (rptr_reg == wptr);
  assign rlevel  = wptr - rptr_reg;
  assign raddr   = rptr_reg[addr_width-1:0];
  assign m_valid = (occ_reg != 2'd0);
  assign m_data  = buf_reg[0];
  assign pop     = m_valid && m_ready;

  // Buffered plus outstanding words may never exceed the two buffer slots,
  // counting the slot freed by a pop in this same cycle.
  assign demand = {1'b0, occ_reg} + {2'b00, inflight_reg};
  assign limit  = 3'd2 + {2'b00, pop};
  assign issue  = rrst_n && !rempty && !flush && (demand < limit);
  assign rclken = issue;

  // A capture lands just behind whatever remains after this cycle's pop.
  assign tail = occ_reg - {1'b0, pop};

  always_comb begin
    rptr_next     = rptr_reg;
    occ_next      = occ_reg;
    inflight_next = inflight_reg;
    buf_next[0]   = buf_reg[0];
    buf_next[1]   = buf_reg[1];
    if (flush) begin
      rptr_next     = wptr;
      occ_next      = 2'd0;
      inflight_next = 1'b0;
    end else begin
      if (issue) begin
        rptr_next = rptr_reg + 1'b1;
      end
      inflight_next = issue;
      if (pop) begin
        buf_next[0] = buf_reg[1];
      end
      if (inflight_reg) begin
        buf_next[tail[0]] = rdata;
      end
      occ_next = occ_reg + {1'b0, inflight_reg} - {1'b0, pop};
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rptr_reg     <= '0;
      occ_reg      <= 2'd0;
      inflight_reg <= 1'b0;
    end else begin
      rptr_reg     <= rptr_next;
      occ_reg      <= occ_next;
      inflight_reg <= inflight_next;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_buf
    always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
        buf_reg[gi] <= '0;
      end else begin
        buf_reg[gi] <= buf_next[gi];
      end
    end
  end

endmodule

// File: tb/tb_fifo_rdctl.sv
// Scoreboard bench for fifo_rdctl: writer pushes expected words, a negedge
// monitor checks addresses, levels and the output stream against the queue.
module tb_fifo_rdctl;
  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic [AW:0]   wptr;
  logic [AW-1:0] raddr;
  logic          rclken;
  logic [DW-1:0] rdata;
  logic          rempty;
  logic [AW:0]   rlevel;
  logic          flush;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [AW:0]   rd_idx;
  logic [AW:0]   mon_lvl;
  logic          hold_prev;
  logic [DW-1:0] data_prev;
  int            checks = 0;
  int            errors = 0;

  fifo_rdctl #(.data_width(DW), .addr_width(AW)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .wptr(wptr), .raddr(raddr), .rclken(rclken),
    .rdata(rdata), .rempty(rempty), .rlevel(rlevel), .flush(flush),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 rclk = ~rclk;

  // Registered-read memory: data appears the cycle after the read is issued.
  always @(posedge rclk) if (rclken) rdata <= mem[raddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic write_words(input int n);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] d;
      d = DW'($urandom);
      mem[wptr[AW-1:0]] = d;
      exp_q.push_back(d);
      wptr = wptr + 1'b1;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    m_ready = 1'b1;
    while ((exp_q.size() != 0 || m_valid || !rempty) && n < 2000) begin
      step();
      n++;
    end
    chk(name, n < 2000, 1);
    repeat (3) step();
  endtask

  // Monitor: model read index advances on each observed read request.
  always @(negedge rclk) begin
    if (!rrst_n) begin
      exp_q.delete();
      rd_idx    = '0;
      hold_prev = 1'b0;
    end else begin
      mon_lvl = wptr - rd_idx;
      chk("rlevel", rlevel, mon_lvl);
      chk("rempty", rempty, mon_lvl == 0);
      if (flush) begin
        chk("rclken_flush", rclken, 0);
        exp_q.delete();
        rd_idx    = wptr;
        hold_prev = 1'b0;
      end else begin
        if (mon_lvl == 0) chk("rclken_empty", rclken, 0);
        if (rclken) begin
          chk("raddr", raddr, rd_idx[AW-1:0]);
          rd_idx = rd_idx + 1'b1;
        end
        if (hold_prev) begin
          chk("hold_valid", m_valid, 1);
          chk("hold_data", m_data, data_prev);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) chk("pop_unexpected", m_valid, 0);
          else chk("stream_data", m_data, exp_q.pop_front());
        end
        hold_prev = m_valid && !m_ready;
        data_prev = m_data;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] abc [3];
    logic [AW-1:0] seen [$];
    logic [AW-1:0] exp032 [4];
    logic [DW-1:0] first;
    int k;

    rrst_n = 1'b0; wptr = '0; flush = 1'b0; m_ready = 1'b0;
    repeat (3) step();
    @(negedge rclk);
    chk("reset_rclken", rclken, 0);
    chk("reset_valid", m_valid, 0);
    chk("reset_data", m_data, 0);
    chk("reset_empty", rempty, 1);
    chk("reset_level", rlevel, 0);
    step();
    wptr = 9'd5;
    @(negedge rclk);
    chk("reset_rclken_gated", rclken, 0);
    chk("reset_level_w5", rlevel, 5);
    step();
    wptr = '0;
    step();
    rrst_n = 1'b1;
    step();

    // Latency and ordering from empty with consumer always ready
    abc[0] = 16'h0A0A; abc[1] = 16'h0B0B; abc[2] = 16'h0C0C;
    for (int i = 0; i < 3; i++) begin
      mem[i] = abc[i];
      exp_q.push_back(abc[i]);
    end
    wptr = 9'd3; m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge rclk);
      chk("t030_rclken", rclken, c < 3);
      chk("t030_valid", m_valid, (c >= 2) && (c <= 4));
      if (c >= 2 && c <= 4) chk("t030_data", m_data, abc[c-2]);
      chk("t030_empty", rempty, c >= 3);
      step();
    end
    drain("t030_drain");

    // Stalled consumer: only two reads issued, head held
    m_ready = 1'b0;
    write_words(5);
    first = exp_q[0];
    repeat (6) step();
    @(negedge rclk);
    chk("t031_valid", m_valid, 1);
    chk("t031_data", m_data, first);
    chk("t031_level", rlevel, 3);
    chk("t031_rclken", rclken, 0);
    step();
    drain("t031_drain");

    // Address wrap across the top of memory
    wptr = 9'h0FE; flush = 1'b1;
    step();
    flush = 1'b0;
    write_words(4);
    m_ready = 1'b1;
    exp032[0] = 8'hFE; exp032[1] = 8'hFF; exp032[2] = 8'h00; exp032[3] = 8'h01;
    for (int c = 0; c < 8; c++) begin
      @(negedge rclk);
      if (rclken) seen.push_back(raddr);
      step();
    end
    chk("t032_count", seen.size(), 4);
    for (int i = 0; i < 4; i++) if (i < seen.size()) chk("t032_raddr", seen[i], exp032[i]);
    @(negedge rclk);
    chk("t032_empty", rempty, 1);
    chk("t032_level", rlevel, 0);
    step();
    drain("t032_drain");

    // Full-depth occupancy reads as non-empty
    m_ready = 1'b0;
    write_words(DEPTH);
    @(negedge rclk);
    chk("t033_empty", rempty, 0);
    chk("t033_level", rlevel, DEPTH);
    step();
    drain("t033_drain");

    // Sustained one word per cycle
    m_ready = 1'b1;
    write_words(20);
    for (int c = 0; c < 23; c++) begin
      @(negedge rclk);
      if (c >= 2 && c < 22) chk("t023_valid", m_valid, 1);
      step();
    end
    drain("t023_drain");

    // Flush right after an issue discards buffer and the in-flight word
    m_ready = 1'b0;
    write_words(5);
    repeat (5) step();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge rclk);
    chk("t034_valid", m_valid, 0);
    chk("t034_empty", rempty, 1);
    step();
    m_ready = 1'b1;
    repeat (6) step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      m_ready = ($urandom_range(0, 9) < 7);
      flush   = ($urandom_range(0, 99) == 0);
      k = $urandom_range(0, 2);
      if ($urandom_range(0, 49) == 0) k = $urandom_range(0, 40);
      if (exp_q.size() + k > DEPTH) k = DEPTH - exp_q.size();
      write_words(k);
      step();
    end
    flush = 1'b0;
    drain("rand_drain");

    // Reset mid-stream, then restart immediately
    m_ready = 1'b1;
    write_words(50);
    repeat (10) step();
    #3;
    rrst_n = 1'b0;
    #1;
    chk("t035_rclken", rclken, 0);
    chk("t035_valid", m_valid, 0);
    chk("t035_data", m_data, 0);
    chk("t035_level", rlevel, wptr);
    step();
    wptr = '0;
    step();
    rrst_n = 1'b1;
    write_words(2);
    @(negedge rclk);
    chk("t029_rclken", rclken, 1);
    chk("t028_valid_after", m_valid, 0);
    step();
    drain("t035_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
